// File: rtl/dsp_alu_pkg.sv
// Shared types and constants for the nibble-serial DSP ALU sequencer.
package dsp_alu_pkg;

  localparam int NIBBLE_W = 4;

  // Sequencer FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP     = 3'd1,
    S_GAP_A  = 3'd2,
    S_SEND_A = 3'd3,
    S_GAP_B  = 3'd4,
    S_SEND_B = 3'd5,
    S_WAIT   = 3'd6,
    S_RESP   = 3'd7
  } seq_state_t;

  // Opcodes as decoded by the ALU.
  localparam logic [NIBBLE_W-1:0] OP_NOP = 4'h0;
  localparam logic [NIBBLE_W-1:0] OP_ADD = 4'h1;
  localparam logic [NIBBLE_W-1:0] OP_SUB = 4'h2;
  localparam logic [NIBBLE_W-1:0] OP_AND = 4'h3;
  localparam logic [NIBBLE_W-1:0] OP_OR  = 4'h4;
  localparam logic [NIBBLE_W-1:0] OP_XOR = 4'h5;

endpackage

// File: rtl/dsp_alu_nibble_tx.sv
// One-nibble transmitter: a start pulse produces one registered strobe
// cycle carrying the nibble, then the gap counter runs down; done is high
// in the last gap cycle so the next start lands exactly GAP_CYCLES later.
module dsp_alu_nibble_tx
  import dsp_alu_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NIBBLE_W-1:0] nibble,
  output logic                process,
  output logic [NIBBLE_W-1:0] data,
  output logic                done
);

  logic [2:0] gap_cnt;

  // Strobe register and shared gap down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      process <= 1'b0;
      data    <= '0;
      gap_cnt <= 3'd0;
    end else if (start) begin
      process <= 1'b1;
      data    <= nibble;
      gap_cnt <= 3'(GAP_CYCLES);
    end else begin
      process <= 1'b0;
      data    <= '0;
      if (gap_cnt != 3'd0) begin
        gap_cnt <= gap_cnt - 3'd1;
      end
    end
  end

  assign done = (gap_cnt == 3'd1);

endmodule

// File: rtl/dsp_alu_sequencer.sv
// Drives the 4-bit sequential ALU: accepts a whole command, sends op/A/B
// as strobed nibbles, waits the ALU latency, then holds result and flags
// on a valid/ready response port. ALU pins lag the FSM state by one cycle
// because they come out of the transmitter's registers.
module dsp_alu_sequencer
  import dsp_alu_pkg::*;
#(
  parameter int GAP_CYCLES  = 1,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [NIBBLE_W-1:0] cmd_op,
  input  logic [NIBBLE_W-1:0] cmd_a,
  input  logic [NIBBLE_W-1:0] cmd_b,
  output logic                alu_process,
  output logic [NIBBLE_W-1:0] alu_data,
  input  logic [NIBBLE_W-1:0] alu_result,
  input  logic [NIBBLE_W-1:0] alu_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NIBBLE_W-1:0] rsp_result,
  output logic [NIBBLE_W-1:0] rsp_flags,
  output logic                busy,
  output logic [7:0]          op_count
);

  seq_state_t          state, state_nxt;
  logic [NIBBLE_W-1:0] op_q, a_q, b_q;
  logic                tx_start;
  logic [NIBBLE_W-1:0] tx_nibble;
  logic                tx_done;
  logic [3:0]          wait_cnt;
  logic                wait_last;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign wait_last = (state == S_WAIT) && (wait_cnt == 4'd1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and transmitter requests.
  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    tx_nibble = '0;
    case (state)
      S_IDLE:   if (cmd_valid) state_nxt = S_OP;
      S_OP: begin
        tx_start  = 1'b1;
        tx_nibble = op_q;
        state_nxt = S_GAP_A;
      end
      S_GAP_A:  if (tx_done) state_nxt = S_SEND_A;
      S_SEND_A: begin
        tx_start  = 1'b1;
        tx_nibble = a_q;
        state_nxt = S_GAP_B;
      end
      S_GAP_B:  if (tx_done) state_nxt = S_SEND_B;
      S_SEND_B: begin
        tx_start  = 1'b1;
        tx_nibble = b_q;
        state_nxt = S_WAIT;
      end
      S_WAIT:   if (wait_last) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Command capture; held unchanged until the sequencer is idle again.
  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      op_q <= cmd_op;
      a_q  <= cmd_a;
      b_q  <= cmd_b;
    end
  end

  dsp_alu_nibble_tx #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (tx_start),
    .nibble  (tx_nibble),
    .process (alu_process),
    .data    (alu_data),
    .done    (tx_done)
  );

  // ALU latency counter, response register and completion counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt   <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      op_count   <= 8'd0;
    end else begin
      if (state == S_SEND_B) begin
        wait_cnt <= 4'(WAIT_CYCLES);
      end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (wait_last) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        op_count   <= op_count + 8'd1;
      end else if ((state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dsp_alu_sequencer.md
Name: dsp_alu_sequencer

Overview:
Drives the 4-bit sequential DSP ALU over its nibble-serial interface: one 4-bit data bus plus a `process` strobe.
- Accepts whole commands (opcode, A, B) through a valid/ready handshake.
- Serialises each command into three strobed nibble transfers, waits the ALU latency, then captures result and flags.
- Returns result and flags through a valid/ready response port.
- Sits between the chip-level command source and the ALU instance, and is the only master of the ALU's `process`/`data` pins.

Parameters:
GAP_CYCLES, 1, idle cycles with alu_process low between consecutive nibble strobes (legal range 1..7).
WAIT_CYCLES, 2, cycles from the B strobe to the alu_result/alu_flags capture (legal range 1..15).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command (high only in IDLE).
cmd_op  input  4  ALU opcode.
cmd_a  input  4  operand A.
cmd_b  input  4  operand B.
alu_process  output  1  nibble strobe to the ALU.
alu_data  output  4  nibble bus to the ALU.
alu_result  input  4  ALU result.
alu_flags  input  4  ALU flags.
rsp_valid  output  1  response held.
rsp_ready  input  1  consumer accepts response.
rsp_result  output  4  captured result.
rsp_flags  output  4  captured flags.
busy  output  1  high in any state other than IDLE.
op_count  output  8  number of completed responses; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; alu_process=0, alu_data=0, rsp_valid=0, rsp_result=0, rsp_flags=0, op_count=0, busy=0, cmd_ready=1. A reset mid-command aborts it with no response. The ALU is reset separately.
- Command accept: command registers latch cmd_op/cmd_a/cmd_b on the clk edge where cmd_valid && cmd_ready. State goes to OP. The command registers are not changed again until IDLE.
- FSM states: IDLE, OP, GAP_A, SEND_A, GAP_B, SEND_B, WAIT, RESP.
- OP: alu_process=1 and alu_data=op for exactly 1 cycle -> GAP_A.
- GAP_A / GAP_B: alu_process=0 and alu_data=0 for GAP_CYCLES cycles, using a shared down-counter.
- GAP_A -> SEND_A: alu_data=A with strobe for 1 cycle -> GAP_B.
- GAP_B -> SEND_B: alu_data=B with strobe for 1 cycle -> WAIT.
- WAIT: WAIT_CYCLES cycles. On the last WAIT cycle edge, alu_result/alu_flags are registered into rsp_result/rsp_flags, rsp_valid is set, op_count increments, and state goes to RESP.
- All ALU-side outputs are registered; no combinational path from cmd_* to alu_*.
- RESP: rsp_valid held and rsp_result/rsp_flags stable until rsp_ready is sampled high. On that edge rsp_valid=0 and state goes to IDLE. If rsp_ready is already high on entry, the response lasts exactly 1 cycle.
- Throughput: no overlap between commands. A new command is accepted no earlier than the cycle after the response handshake.
- Command-to-rsp_valid latency, counted from the accept edge: 3 + 2*GAP_CYCLES + WAIT_CYCLES cycles (7 at defaults).
- cmd_valid deasserted while not in IDLE: ignored. cmd_* changes after accept: no effect.
- rsp_ready high with rsp_valid low: no effect.
- op_count at 255 plus one completion -> 0, no sticky flag.

Decomposition:
- Shared package dsp_alu_pkg holds:
  - state enum seq_state_t (3-bit encoding);
  - NIBBLE_W=4;
  - opcode constants matching the ALU decode.
- One natural sub-module, dsp_alu_nibble_tx: takes a nibble, emits one strobed transfer, then counts the gap and raises a done pulse. Instantiated once and reused for the op, A and B transfers.
- The FSM, response register and op_count stay in the top module.

Test Plan:
1. Reset then idle: hold reset_n=0 for 3 cycles, release -> cmd_ready=1, busy=0, alu_process=0, rsp_valid=0, op_count=0.
2. Single command, defaults: op=4'h1, A=4'h3, B=4'h5, rsp_ready=1; ALU model returns result 4'h8, flags 4'h0.
   - alu_process pulses on cycles 1, 3, 5 after accept, carrying data 1, 3, 5.
   - rsp_valid rises on cycle 7 with rsp_result=8, rsp_flags=0; op_count=1.
3. Response backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
   - rsp_valid stays 1 and rsp_result/rsp_flags stay stable; cmd_ready=0; a second cmd_valid is not accepted.
   - Raise rsp_ready -> IDLE next cycle.
4. Input change after accept: change cmd_a to 4'hF one cycle after accept -> ALU still sees 4'h3 on the A strobe.
5. Reset mid-operation: assert reset_n=0 while in WAIT -> outputs reach reset values immediately (async); no response is produced; op_count=0.
6. Counter wrap with GAP_CYCLES=3, WAIT_CYCLES=4: run 256 back-to-back commands.
   - Strobe spacing is 4 cycles; latency is 13 cycles.
   - op_count reads 255 after the 255th response and 0 after the 256th.
